// File: rtl/result_bcd_formatter_if.sv
// Handshake bundle between the ALU result source and the BCD formatter.
// master drives the result and done flag; slave (the formatter) returns the digits.
interface result_bcd_formatter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIGITS = 3
);
   logic [DATA_W-1:0]   result_uncoded;
   logic                alu_done;
   logic [DIGITS*4-1:0] bcd_out;
   logic                sign;
   logic [DIGITS-1:0]   digit_blank;
   logic                bcd_valid;
   logic                busy;
   logic                overrun;

   modport master (
      output result_uncoded, alu_done,
      input  bcd_out, sign, digit_blank, bcd_valid, busy, overrun
   );

   modport slave (
      input  result_uncoded, alu_done,
      output bcd_out, sign, digit_blank, bcd_valid, busy, overrun
   );
endinterface

// File: rtl/result_bcd_formatter.sv
// Sequential double-dabble binary-to-BCD converter (one shift per clock) with blanking flags.
// Define SIGNED_RESULT_EN to treat the input as two's complement and report a sign.
module result_bcd_formatter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIGITS = 3
) (
   input logic                    clk,
   input logic                    rst,
   result_bcd_formatter_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam int unsigned BCD_W = DIGITS * 4;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q;
   logic              alu_done_q;
   logic [DATA_W-1:0] shift_q;
   logic [BCD_W-1:0]  scratch_q;
   logic [BCD_W-1:0]  scratch_adj;
   logic [CNT_W-1:0]  cnt_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [DIGITS-1:0] blank_q;
   logic [DIGITS-1:0] blank_d;
   logic              zero_above;
   logic              valid_q;
   logic              busy_q;
   logic              overrun_q;
   logic              sign_lat_q;
   logic              sign_q;
   logic              start;
   logic              sign_in;
   logic [DATA_W-1:0] magnitude;

   assign start = bus.alu_done & ~alu_done_q;

`ifdef SIGNED_RESULT_EN
   // Negation truncated to DATA_W bits still yields 2**(DATA_W-1) for the most negative input.
   assign sign_in   = bus.result_uncoded[DATA_W-1];
   assign magnitude = sign_in ? -bus.result_uncoded : bus.result_uncoded;
`else
   assign sign_in   = 1'b0;
   assign magnitude = bus.result_uncoded;
`endif

   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[i*4 +: 4] >= 4'd5) begin
            scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
         end
      end
   end

   // A digit is blanked only if it and every more significant digit are zero; units never blank.
   always_comb begin
      blank_d    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (scratch_q[i*4 +: 4] == 4'd0);
         blank_d[i] = zero_above;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         alu_done_q <= 1'b0;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         blank_q    <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         sign_lat_q <= 1'b0;
         sign_q     <= 1'b0;
      end else begin
         alu_done_q <= bus.alu_done;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  shift_q    <= magnitude;
                  scratch_q  <= '0;
                  cnt_q      <= '0;
                  sign_lat_q <= sign_in;
                  busy_q     <= 1'b1;
                  state_q    <= StShift;
               end
            end
            StShift: begin
               overrun_q              <= start;
               {scratch_q, shift_q}   <= {scratch_adj, shift_q} << 1;
               cnt_q                  <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               overrun_q <= start;
               bcd_q     <= scratch_q;
               blank_q   <= blank_d;
               sign_q    <= sign_lat_q;
               valid_q   <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.digit_blank = blank_q;
   assign bus.sign        = sign_q;
   assign bus.bcd_valid   = valid_q;
   assign bus.busy        = busy_q;
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_result_bcd_formatter.sv
// Scoreboard bench for result_bcd_formatter; expected digits come from an integer model.
// Works for both the default and the SIGNED_RESULT_EN build.
module tb_result_bcd_formatter;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DIGITS = 3;

   typedef struct packed {
      logic [11:0] bcd;
      logic [2:0]  blank;
      logic        sign;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   exp_t sb_q[$];
   int   tests     = 0;
   int   fails     = 0;
   int   n_valid   = 0;
   int   n_overrun = 0;

   always #5 clk = ~clk;

   result_bcd_formatter_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

   result_bcd_formatter #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] v);
      exp_t e;
      int   mag;
`ifdef SIGNED_RESULT_EN
      e.sign = v[7];
      mag    = v[7] ? 256 - int'(v) : int'(v);
`else
      e.sign = 1'b0;
      mag    = int'(v);
`endif
      e.bcd   = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
      e.blank = {mag < 100, mag < 10, 1'b0};
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (bus.overrun) n_overrun++;
      if (bus.bcd_valid) begin
         n_valid++;
         check_eq("sb_nonempty", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("bcd_out", bus.bcd_out, e.bcd);
            check_eq("digit_blank", bus.digit_blank, e.blank);
            check_eq("sign", bus.sign, e.sign);
         end
      end
   end

   // Starts a conversion on the next edge and waits for bcd_valid, checking latency and busy.
   task automatic run_conv(input logic [7:0] v);
      int edges;
      int busy_cyc;
      bus.result_uncoded = v;
      bus.alu_done       = 1'b1;
      sb_q.push_back(model(v));
      @(posedge clk);
      #1 bus.alu_done = 1'b0;
      edges    = 0;
      busy_cyc = 0;
      while (!bus.bcd_valid && edges < 20) begin
         if (bus.busy) busy_cyc++;
         @(posedge clk);
         #1;
         edges++;
      end
      check_eq("latency", edges, 9);
      check_eq("busy_cycles", busy_cyc, 9);
      check_eq("busy_low_on_valid", bus.busy, 0);
   endtask

   initial begin
      logic [7:0] vals [9];
      int         v0;
      int         o0;
      vals = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'h09, 8'h0A, 8'h63, 8'h64};
      bus.alu_done       = 1'b0;
      bus.result_uncoded = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_bcd_out", bus.bcd_out, 0);
      check_eq("rst_blank", bus.digit_blank, 0);
      check_eq("rst_sign", bus.sign, 0);
      check_eq("rst_valid", bus.bcd_valid, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_overrun", bus.overrun, 0);
      rst = 1'b1;

      // First edge after release counts as a start; runs are issued back to back.
      foreach (vals[i]) run_conv(vals[i]);
      for (int i = 0; i < 4; i++) run_conv(8'($urandom_range(0, 255)));

      // Level held high for five cycles gives a single conversion.
      repeat (2) @(posedge clk);
      #1;
      v0                 = n_valid;
      bus.result_uncoded = 8'h2A;
      bus.alu_done       = 1'b1;
      sb_q.push_back(model(8'h2A));
      repeat (5) @(posedge clk);
      #1 bus.alu_done = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_eq("hold_one_valid", n_valid - v0, 1);

      // Second rise three clocks into a conversion is dropped and flagged.
      v0                 = n_valid;
      o0                 = n_overrun;
      bus.result_uncoded = 8'h10;
      bus.alu_done       = 1'b1;
      sb_q.push_back(model(8'h10));
      @(posedge clk);
      #1 bus.alu_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.result_uncoded = 8'h63;
      bus.alu_done       = 1'b1;
      @(posedge clk);
      #1 bus.alu_done = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check_eq("overrun_pulses", n_overrun - o0, 1);
      check_eq("overrun_one_valid", n_valid - v0, 1);
      run_conv(8'h63);

      // Reset at E4 aborts the conversion without a valid strobe.
      repeat (2) @(posedge clk);
      #1;
      v0                 = n_valid;
      bus.result_uncoded = 8'h99;
      bus.alu_done       = 1'b1;
      @(posedge clk);
      #1 bus.alu_done = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_eq("abort_bcd_out", bus.bcd_out, 0);
      check_eq("abort_blank", bus.digit_blank, 0);
      check_eq("abort_busy", bus.busy, 0);
      check_eq("abort_valid", bus.bcd_valid, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_eq("abort_no_valid", n_valid - v0, 0);
      run_conv(8'h05);

      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
